// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line, oversampled 3-sample majority vote,
// optional parity, 1/2 stop bits, valid/ready word hand-off with overrun pulse.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned S_W     = $clog2(OVERSAMPLE);
  localparam int unsigned M       = OVERSAMPLE / 2;
  localparam int unsigned BC_W    = 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   SMP_PRE   = S_W'(M - 1);
  localparam logic [S_W-1:0]   SMP_MID   = S_W'(M);
  localparam logic [S_W-1:0]   SMP_DEC   = S_W'(M + 1);
  localparam logic [S_W-1:0]   SMP_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_armed;
  logic [S_W-1:0]       r_s;
  logic                 r_smp_a;
  logic                 r_smp_b;
  logic [BC_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_pend;
  logic                 r_frm_pend;
  logic                 r_done;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_overrun;

  logic                 w_tick;
  logic [S_W-1:0]       w_s;
  logic                 w_dec;
  logic                 w_bit_end;
  logic                 w_maj;
  logic                 w_par_exp;
  logic                 w_start;
  logic                 w_glitch;
  logic                 w_shift;
  logic                 w_par_chk;
  logic                 w_stop_chk;
  logic                 w_frame_end;

  // Tick generator and line synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // w_s is the sample index of the current tick; the start-detect tick is index 0
  always_comb begin
    w_tick    = (r_div_cnt == DIV_LAST);
    w_s       = (r_s == SMP_LAST) ? '0 : r_s + 1'b1;
    w_dec     = w_tick && (w_s == SMP_DEC);
    w_bit_end = w_tick && (w_s == SMP_LAST);
    w_maj     = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_sync) | (r_smp_b & r_rx_sync);
    w_par_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_tick && r_armed && !r_rx_sync) w_next = ST_START;
      end
      ST_START: begin
        if (w_dec && w_maj)  w_next = ST_IDLE;
        else if (w_bit_end)  w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == DATA_LAST))
          w_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_bit_end) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_dec && (r_bit_cnt == STOP_LAST)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != ST_IDLE);
    w_start     = (r_state == ST_IDLE) && w_tick && r_armed && !r_rx_sync;
    w_glitch    = (r_state == ST_START) && w_dec && w_maj;
    w_shift     = (r_state == ST_DATA) && w_dec;
    w_par_chk   = (r_state == ST_PARITY) && w_dec;
    w_stop_chk  = (r_state == ST_STOP) && w_dec;
    w_frame_end = w_stop_chk && (r_bit_cnt == STOP_LAST);
  end

  // Arming only counts idle-line samples, so a held-low break yields one frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (w_start) begin
      r_armed <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_tick && r_rx_sync) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s       <= '0;
      r_smp_a   <= 1'b1;
      r_smp_b   <= 1'b1;
      r_bit_cnt <= '0;
    end else begin
      if (w_start)     r_s <= '0;
      else if (w_tick) r_s <= w_s;
      if (w_tick && (w_s == SMP_PRE)) r_smp_a <= r_rx_sync;
      if (w_tick && (w_s == SMP_MID)) r_smp_b <= r_rx_sync;
      if (w_next != r_state)
        r_bit_cnt <= '0;
      else if (w_bit_end && ((r_state == ST_DATA) || (r_state == ST_STOP)))
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_start) begin
        r_par_pend <= 1'b0;
        r_frm_pend <= 1'b0;
      end
      if (w_shift)    r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (w_par_chk)  r_par_pend <= (w_maj != w_par_exp);
      if (w_stop_chk) r_frm_pend <= r_frm_pend | ~w_maj;
    end
  end

  // A word completing while the held one is being consumed replaces it without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || data_ready) begin
          r_data    <= r_shift;
          r_par_err <= r_par_pend;
          r_frm_err <= r_frm_pend;
          r_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_par_err;
  assign frame_err  = r_frm_err;
  assign overrun    = r_overrun;

endmodule
